// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_pipe_pkg : shared pipeline types and constants for MEM/WB staging  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package riscv_pipe_pkg;

    localparam int WB_XLEN   = 64;
    localparam int WB_REG_AW = 5;
    localparam int REG_X0    = 0;

    // Writeback bundle at the default core widths; field order is the packing order.
    typedef struct packed {
        logic [WB_REG_AW-1:0] rd;
        logic                 regwrite;
        logic                 memtoreg;
        logic [WB_XLEN-1:0]   alu;
        logic [WB_XLEN-1:0]   rdata;
    } wb_bundle_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_skid_buf : 2-entry valid/ready skid buffer with flush (W-bit data)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipe_skid_buf #(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic         accept;
    logic         drain;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign drain     = main_valid_q & out_ready;
    assign accept    = in_valid & in_ready;

    generate
        if (SKID_EN) begin : g_skid
            logic         skid_valid_q, skid_valid_d;
            logic [W-1:0] skid_data_q, skid_data_d;

            // Ready comes straight from a flop, so MEM never sees a path from out_ready.
            assign in_ready = ~skid_valid_q;

            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (drain) begin
                    main_valid_d = 1'b0;
                end
                if (drain && skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    if (!main_valid_q || drain) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end
                end
                if (flush) begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= '0;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                end
            end
        end else begin : g_noskid
            assign in_ready = out_ready | ~main_valid_q;

            always_comb begin
                main_valid_d = main_valid_q & ~drain;
                main_data_d  = main_data_q;
                if (accept) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end
                if (flush) begin
                    main_valid_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wb_skid_stage : MEM->WB stage register, writeback mux, commit strobe |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_wb_skid_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int REG_AW  = 5,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_regwrite,
    output logic [XLEN-1:0]   out_wb_data,
    output logic              out_memtoreg,
    output logic              commit
);

    // Same layout as riscv_pipe_pkg::wb_bundle_t, resized to this instance's widths.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memtoreg;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rdata;
    } wb_slot_t;

    localparam int W = $bits(wb_slot_t);

    wb_slot_t in_slot;
    wb_slot_t out_slot;

    // x0 qualification happens once at capture so commit needs no compare.
    always_comb begin
        in_slot          = '0;
        in_slot.rd       = in_rd;
        in_slot.regwrite = in_regwrite & (in_rd != REG_AW'(REG_X0));
        in_slot.memtoreg = in_memtoreg;
        in_slot.alu      = in_alu;
        in_slot.rdata    = in_rdata;
    end

    pipe_skid_buf #(
        .W       (W),
        .SKID_EN (SKID_EN)
    ) u_skid_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_slot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_slot)
    );

    assign out_rd       = out_slot.rd;
    assign out_regwrite = out_slot.regwrite;
    assign out_memtoreg = out_slot.memtoreg;

    // Gated to zero when empty so the forwarding mux never sees stale data.
    assign out_wb_data  = out_valid ? (out_slot.memtoreg ? out_slot.rdata : out_slot.alu) : '0;
    assign commit       = out_valid & out_ready & out_slot.regwrite;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_wb_skid_stage : FIFO-model checked bench for both SKID_EN builds  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_wb_skid_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid     [2];
    logic        in_ready     [2];
    logic [4:0]  in_rd        [2];
    logic        in_regwrite  [2];
    logic        in_memtoreg  [2];
    logic [63:0] in_alu       [2];
    logic [63:0] in_rdata     [2];
    logic        out_valid    [2];
    logic        out_ready    [2];
    logic [4:0]  out_rd       [2];
    logic        out_regwrite [2];
    logic [63:0] out_wb_data  [2];
    logic        out_memtoreg [2];
    logic        commit       [2];

    int total = 0;
    int bad   = 0;

    mem_wb_skid_stage #(.XLEN(64), .REG_AW(5), .SKID_EN(1'b1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_rd(in_rd[0]),
        .in_regwrite(in_regwrite[0]), .in_memtoreg(in_memtoreg[0]),
        .in_alu(in_alu[0]), .in_rdata(in_rdata[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_rd(out_rd[0]),
        .out_regwrite(out_regwrite[0]), .out_wb_data(out_wb_data[0]),
        .out_memtoreg(out_memtoreg[0]), .commit(commit[0])
    );

    mem_wb_skid_stage #(.XLEN(64), .REG_AW(5), .SKID_EN(1'b0)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_rd(in_rd[1]),
        .in_regwrite(in_regwrite[1]), .in_memtoreg(in_memtoreg[1]),
        .in_alu(in_alu[1]), .in_rdata(in_rdata[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_rd(out_rd[1]),
        .out_regwrite(out_regwrite[1]), .out_wb_data(out_wb_data[1]),
        .out_memtoreg(out_memtoreg[1]), .commit(commit[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: each DUT is a FIFO of capacity 2 (skid) or 1 (no skid).
    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic [63:0] alu;
        logic [63:0] rdata;
    } ent_t;

    ent_t mq [2][4];
    int   mcnt [2];
    bit   live = 1'b0;

    function automatic bit m_ready(input int d);
        if (d == 0) return mcnt[0] < 2;
        return out_ready[1] || (mcnt[1] == 0);
    endfunction

    always @(posedge clk) begin
        bit rdy;
        bit pop;
        bit push;
        for (int d = 0; d < 2; d++) begin
            rdy  = m_ready(d);
            pop  = (mcnt[d] > 0) && out_ready[d];
            push = in_valid[d] && rdy;
            if (reset || flush) begin
                mcnt[d] = 0;
            end else begin
                if (pop) begin
                    for (int k = 0; k < 3; k++) mq[d][k] = mq[d][k+1];
                    mcnt[d]--;
                end
                if (push) begin
                    mq[d][mcnt[d]] = '{rd: in_rd[d], rw: in_regwrite[d], m2r: in_memtoreg[d],
                                       alu: in_alu[d], rdata: in_rdata[d]};
                    mcnt[d]++;
                end
            end
        end
        if (reset) live = 1'b1;
    end

    always @(negedge clk) begin
        bit          ev;
        bit          erw;
        logic [63:0] ewb;
        if (live) begin
            for (int d = 0; d < 2; d++) begin
                ev  = mcnt[d] > 0;
                erw = ev && mq[d][0].rw && (mq[d][0].rd != 5'd0);
                ewb = !ev ? 64'd0 : (mq[d][0].m2r ? mq[d][0].rdata : mq[d][0].alu);
                chk("m_out_valid", d, out_valid[d], ev);
                chk("m_in_ready", d, in_ready[d], m_ready(d));
                chk("m_commit", d, commit[d], erw && out_ready[d]);
                chk("m_wb_data", d, out_wb_data[d], ewb);
                if (ev) begin
                    chk("m_out_rd", d, out_rd[d], mq[d][0].rd);
                    chk("m_out_regwrite", d, out_regwrite[d], erw);
                    chk("m_out_memtoreg", d, out_memtoreg[d], mq[d][0].m2r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit v, input logic [4:0] rd, input bit rw,
                         input bit m2r, input logic [63:0] alu, input logic [63:0] rdata);
        in_valid[d]    = v;
        in_rd[d]       = rd;
        in_regwrite[d] = rw;
        in_memtoreg[d] = m2r;
        in_alu[d]      = alu;
        in_rdata[d]    = rdata;
    endtask

    task automatic stream(input int d);
        out_ready[d] = 1'b1;
        drive(d, 1, 5'd5, 1, 0, 64'h10, 64'h0);
        tick();
        drive(d, 1, 5'd6, 1, 1, 64'h99, 64'hABCD);
        @(negedge clk);
        chk("stream_wb0", d, out_wb_data[d], 64'h10);
        chk("stream_commit0", d, commit[d], 1);
        chk("stream_rd0", d, out_rd[d], 5);
        tick();
        drive(d, 0, 5'd0, 0, 0, 64'h0, 64'h0);
        @(negedge clk);
        chk("stream_wb1", d, out_wb_data[d], 64'hABCD);
        chk("stream_commit1", d, commit[d], 1);
        chk("stream_rd1", d, out_rd[d], 6);
        tick();
        @(negedge clk);
        chk("stream_idle_valid", d, out_valid[d], 0);
        chk("stream_idle_wb", d, out_wb_data[d], 0);
        tick();
    endtask

    task automatic backpressure(input int d);
        logic [4:0]  rds [3];
        logic        m2s [3];
        logic [63:0] alus[3];
        logic [63:0] rdts[3];
        logic [63:0] want[3];
        logic [63:0] got [3];
        int          idx;
        int          got_n;
        bit          acc;
        rds  = '{5'd10, 5'd11, 5'd12};
        m2s  = '{1'b0, 1'b1, 1'b0};
        alus = '{64'hA1, 64'h5555, 64'hC3};
        rdts = '{64'h7777, 64'hB2, 64'h8888};
        want = '{64'hA1, 64'hB2, 64'hC3};
        idx  = 0;
        out_ready[d] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (idx < 3) drive(d, 1, rds[idx], 1, m2s[idx], alus[idx], rdts[idx]);
            @(negedge clk);
            acc = in_valid[d] && in_ready[d];
            tick();
            if (acc) idx++;
        end
        if (idx < 3) drive(d, 1, rds[idx], 1, m2s[idx], alus[idx], rdts[idx]);
        @(negedge clk);
        chk("bp_accepted_in_stall", d, idx, (d == 0) ? 2 : 1);
        chk("bp_stall_valid", d, out_valid[d], 1);
        chk("bp_stall_wb_stable", d, out_wb_data[d], 64'hA1);
        chk("bp_stall_in_ready", d, in_ready[d], 0);
        #2;
        out_ready[d] = 1'b1;
        #1;
        chk("bp_in_ready_after_release", d, in_ready[d], (d == 0) ? 0 : 1);
        got_n = 0;
        if (out_valid[d] && out_ready[d]) begin
            got[got_n] = out_wb_data[d];
            got_n++;
        end
        acc = in_valid[d] && in_ready[d];
        for (int c = 0; c < 12 && got_n < 3; c++) begin
            tick();
            if (acc) idx++;
            if (idx < 3) drive(d, 1, rds[idx], 1, m2s[idx], alus[idx], rdts[idx]);
            else         drive(d, 0, 5'd0, 0, 0, 64'h0, 64'h0);
            @(negedge clk);
            if (out_valid[d] && out_ready[d] && got_n < 3) begin
                got[got_n] = out_wb_data[d];
                got_n++;
            end
            acc = in_valid[d] && in_ready[d];
        end
        chk("bp_drained_count", d, got_n, 3);
        for (int k = 0; k < got_n; k++) chk("bp_order", d, got[k], want[k]);
        drive(d, 0, 5'd0, 0, 0, 64'h0, 64'h0);
        tick();
    endtask

    task automatic x0_test(input int d);
        out_ready[d] = 1'b1;
        drive(d, 1, 5'd0, 1, 0, 64'hFFFF, 64'h0);
        tick();
        drive(d, 0, 5'd0, 0, 0, 64'h0, 64'h0);
        @(negedge clk);
        chk("x0_valid", d, out_valid[d], 1);
        chk("x0_regwrite", d, out_regwrite[d], 0);
        chk("x0_commit", d, commit[d], 0);
        chk("x0_wb", d, out_wb_data[d], 64'hFFFF);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 5'd0, 0, 0, 64'h0, 64'h0);
            out_ready[d] = 1'b1;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset in the middle of stalled traffic.
        for (int d = 0; d < 2; d++) begin
            out_ready[d] = 1'b0;
            drive(d, 1, 5'd1, 1, 0, 64'h11, 64'h0);
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 5'd0, 0, 0, 64'h0, 64'h0);
            out_ready[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, out_valid[d], 0);
            chk("rst_commit", d, commit[d], 0);
            chk("rst_wb", d, out_wb_data[d], 0);
            chk("rst_in_ready", d, in_ready[d], 1);
            chk("rst_out_rd", d, out_rd[d], 0);
        end
        tick();

        for (int d = 0; d < 2; d++) stream(d);
        for (int d = 0; d < 2; d++) backpressure(d);
        for (int d = 0; d < 2; d++) x0_test(d);

        // Flush with both skid slots full and a new input offered.
        out_ready[0] = 1'b0;
        drive(0, 1, 5'd3, 1, 0, 64'h33, 64'h0);
        tick();
        drive(0, 1, 5'd4, 1, 0, 64'h44, 64'h0);
        tick();
        drive(0, 1, 5'd9, 1, 0, 64'h99, 64'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready[0] = 1'b1;
        drive(0, 0, 5'd0, 0, 0, 64'h0, 64'h0);
        @(negedge clk);
        chk("flush_full_valid", 0, out_valid[0], 0);
        chk("flush_full_in_ready", 0, in_ready[0], 1);
        tick();

        // Older entry still retires in the flush cycle; the offered input is dropped.
        drive(0, 1, 5'd7, 1, 0, 64'h70, 64'h0);
        tick();
        drive(0, 1, 5'd8, 1, 0, 64'h80, 64'h0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_commit", 0, commit[0], 1);
        chk("flush_cycle_wb", 0, out_wb_data[0], 64'h70);
        tick();
        flush = 1'b0;
        drive(0, 1, 5'd2, 1, 0, 64'h22, 64'h0);
        @(negedge clk);
        chk("flush_discard", 0, out_valid[0], 0);
        tick();
        drive(0, 0, 5'd0, 0, 0, 64'h0, 64'h0);
        @(negedge clk);
        chk("fresh_commit", 0, commit[0], 1);
        chk("fresh_wb", 0, out_wb_data[0], 64'h22);
        chk("fresh_rd", 0, out_rd[0], 2);
        tick();

        // Reset and flush together behave as reset.
        drive(0, 1, 5'd13, 1, 1, 64'h0, 64'hD0);
        out_ready[0] = 1'b0;
        tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        drive(0, 0, 5'd0, 0, 0, 64'h0, 64'h0);
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("rstflush_valid", 0, out_valid[0], 0);
        chk("rstflush_in_ready", 0, in_ready[0], 1);
        chk("rstflush_wb", 0, out_wb_data[0], 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
